// File: rtl/fp_wire.sv
// rtl/fp_wire.sv - shared record types and constants for the FP rounding stage
package fp_wire;

    localparam int EXP_W  = 14;
    localparam int MANT_W = 54;

    typedef struct packed {
        logic              sig;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W-1:0] mant;
        logic [1:0]        rema;
        logic [1:0]        fmt;
        logic [2:0]        rm;
        logic [2:0]        grs;
        logic              snan;
        logic              qnan;
        logic              dbz;
        logic              inf;
        logic              zero;
    } fp_rnd_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_rnd_out_type;

    // Stage-1 register: mant already holds the rounded value plus one carry bit.
    typedef struct packed {
        logic              valid;
        logic              sig;
        logic [EXP_W-1:0]  expo;
        logic [MANT_W-1:0] mant;
        logic [1:0]        fmt;
        logic [2:0]        rm;
        logic              inexact;
        logic              tiny;
        logic              snan;
        logic              qnan;
        logic              dbz;
        logic              inf;
        logic              zero;
    } fp_rnd_pipe_reg_type;

    localparam logic [1:0] FMT_S = 2'd0;
    localparam logic [1:0] FMT_D = 2'd1;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam logic signed [EXP_W-1:0] EXP_LIM_S = 14'sd255;
    localparam logic signed [EXP_W-1:0] EXP_LIM_D = 14'sd2047;

    localparam logic [63:0] NAN_S = 64'hFFFF_FFFF_7FC0_0000;
    localparam logic [63:0] NAN_D = 64'h7FF8_0000_0000_0000;

    localparam logic [30:0] INF_S_MAG = 31'h7F80_0000;
    localparam logic [30:0] MAX_S_MAG = 31'h7F7F_FFFF;
    localparam logic [62:0] INF_D_MAG = 63'h7FF0_0000_0000_0000;
    localparam logic [62:0] MAX_D_MAG = 63'h7FEF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] box_s(input logic sig, input logic [30:0] mag);
        return {32'hFFFF_FFFF, sig, mag};
    endfunction

endpackage

// File: rtl/fp_rnd_pack.sv
// rtl/fp_rnd_pack.sv - combinational normalise, overflow and special-case packing
module fp_rnd_pack
    import fp_wire::*;
(
    input  fp_rnd_pipe_reg_type i_s1,
    output logic [63:0]         o_result,
    output logic [4:0]          o_flags
);

    logic             w_dbl;
    logic             w_carry;
    logic             w_hidden;
    logic             w_ovf;
    logic             w_to_inf;
    logic [52:0]      w_mant;
    logic [EXP_W-1:0] w_expo;
    logic             w_unused;

    assign w_unused = i_s1.valid;

    always_comb begin
        w_dbl   = (i_s1.fmt == FMT_D);
        w_carry = w_dbl ? i_s1.mant[53] : i_s1.mant[24];
        if (w_dbl) begin
            w_mant = w_carry ? i_s1.mant[53:1] : i_s1.mant[52:0];
        end else begin
            w_mant = {29'd0, (w_carry ? i_s1.mant[24:1] : i_s1.mant[23:0])};
        end
        w_hidden = w_dbl ? w_mant[52] : w_mant[23];
        w_expo   = i_s1.expo + {{(EXP_W-1){1'b0}}, w_carry};
        // A subnormal that rounds into the hidden bit becomes the smallest normal.
        if (w_expo == '0 && w_hidden) begin
            w_expo = {{(EXP_W-1){1'b0}}, 1'b1};
        end
        w_ovf = $signed(w_expo) >= (w_dbl ? EXP_LIM_D : EXP_LIM_S);

        case (i_s1.rm)
            RM_RTZ:  w_to_inf = 1'b0;
            RM_RDN:  w_to_inf = i_s1.sig;
            RM_RUP:  w_to_inf = ~i_s1.sig;
            default: w_to_inf = 1'b1;
        endcase

        o_flags = {2'b00, w_ovf, i_s1.tiny & i_s1.inexact, i_s1.inexact | w_ovf};
        if (w_dbl) begin
            o_result = w_ovf ? {i_s1.sig, (w_to_inf ? INF_D_MAG : MAX_D_MAG)}
                             : {i_s1.sig, w_expo[10:0], w_mant[51:0]};
        end else begin
            o_result = box_s(i_s1.sig, w_ovf ? (w_to_inf ? INF_S_MAG : MAX_S_MAG)
                                             : {w_expo[7:0], w_mant[22:0]});
        end

        if (i_s1.fmt[1]) begin
            o_result = NAN_D;
            o_flags  = 5'b10000;
        end else if (i_s1.snan | i_s1.qnan) begin
            o_result = w_dbl ? NAN_D : NAN_S;
            o_flags  = {i_s1.snan, 4'b0000};
        end else if (i_s1.inf | i_s1.dbz) begin
            o_result = w_dbl ? {i_s1.sig, INF_D_MAG} : box_s(i_s1.sig, INF_S_MAG);
            o_flags  = {1'b0, i_s1.dbz & ~i_s1.inf, 3'b000};
        end else if (i_s1.zero) begin
            o_result = w_dbl ? {i_s1.sig, 63'd0} : box_s(i_s1.sig, 31'd0);
            o_flags  = 5'b00000;
        end
    end

endmodule

// File: rtl/fp_rnd_pipe.sv
// rtl/fp_rnd_pipe.sv - two-stage IEEE-754 rounding/packing pipeline with valid/ready
module fp_rnd_pipe
    import fp_wire::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  fp_rnd_in_type fp_rnd_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   result,
    output logic [4:0]    flags
);

    fp_rnd_pipe_reg_type r_s1;
    fp_rnd_pipe_reg_type w_s1_next;
    logic                r_s2_valid;
    logic [63:0]         r_result;
    logic [4:0]          r_flags;

    logic                w_adv;
    logic                w_inc;
    logic                w_inexact;
    logic [MANT_W-1:0]   w_mant_sel;
    logic [63:0]         w_pack_result;
    logic [4:0]          w_pack_flags;
    fp_rnd_out_type      w_rnd_o;
    logic                w_unused;

    assign w_adv    = ~r_s2_valid | out_ready;
    assign w_unused = ^{fp_rnd_i.rema, fp_rnd_i.mant[53]};

    always_comb begin
        w_inexact = |fp_rnd_i.grs;
        case (fp_rnd_i.rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = fp_rnd_i.sig & w_inexact;
            RM_RUP:  w_inc = ~fp_rnd_i.sig & w_inexact;
            RM_RMM:  w_inc = fp_rnd_i.grs[2];
            default: w_inc = fp_rnd_i.grs[2] & (fp_rnd_i.mant[0] | fp_rnd_i.grs[1] | fp_rnd_i.grs[0]);
        endcase
        w_mant_sel = (fp_rnd_i.fmt == FMT_D) ? {1'b0, fp_rnd_i.mant[52:0]}
                                             : {30'd0, fp_rnd_i.mant[23:0]};

        w_s1_next         = '0;
        w_s1_next.valid   = in_valid;
        w_s1_next.sig     = fp_rnd_i.sig;
        w_s1_next.expo    = fp_rnd_i.expo;
        w_s1_next.mant    = w_mant_sel + {{(MANT_W-1){1'b0}}, w_inc};
        w_s1_next.fmt     = fp_rnd_i.fmt;
        w_s1_next.rm      = fp_rnd_i.rm;
        w_s1_next.inexact = w_inexact;
        w_s1_next.tiny    = (fp_rnd_i.expo == '0);
        w_s1_next.snan    = fp_rnd_i.snan;
        w_s1_next.qnan    = fp_rnd_i.qnan;
        w_s1_next.dbz     = fp_rnd_i.dbz;
        w_s1_next.inf     = fp_rnd_i.inf;
        w_s1_next.zero    = fp_rnd_i.zero;
    end

    fp_rnd_pack u_pack (
        .i_s1     (r_s1),
        .o_result (w_pack_result),
        .o_flags  (w_pack_flags)
    );

    // clear only kills the valids; data registers are left as don't-care.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1       <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (clear) begin
            r_s1.valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1       <= w_s1_next;
            r_s2_valid <= r_s1.valid;
            r_result   <= w_pack_result;
            r_flags    <= w_pack_flags;
        end
    end

    assign w_rnd_o   = '{result: r_result, flags: r_flags, ready: w_adv};
    assign in_ready  = w_rnd_o.ready;
    assign result    = w_rnd_o.result;
    assign flags     = w_rnd_o.flags;
    assign out_valid = r_s2_valid;

endmodule
